ahb_resp_mux: RTL and testbench
===============================

AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 SHALL have parameter NSLV, default 9, meaning the number of slave response channels (2..32).
REQ-002 SHALL have parameter DW, default 32, meaning the read-data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port hsel, input, NSLV bits: address-phase slave select, one bit per slave, intended one-hot.
REQ-006 SHALL have port htrans, input, 2 bits: address-phase transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-007 SHALL have port hrdata_s, input, NSLV*DW bits: slave k read data in bits [k*DW +: DW].
REQ-008 SHALL have port hreadyout_s, input, NSLV bits: per-slave HREADYOUT.
REQ-009 SHALL have port hresp_s, input, NSLV bits: per-slave HRESP (0=OKAY, 1=ERROR).
REQ-010 SHALL have port hrdata, output, DW bits: muxed read data to the master.
REQ-011 SHALL have port hready, output, 1 bit: muxed HREADY to the master; also the bus HREADY fed back to all slaves.
REQ-012 SHALL have port hresp, output, 1 bit: muxed HRESP to the master.
REQ-013 SHALL have port onehot_err, output, 1 bit: sticky flag for a multi-hot hsel.

Function
REQ-014 SHALL sample the address phase only in cycles where hready=1; when hready=0, all address-phase inputs are ignored and the data-phase state holds.
REQ-015 On sampling, SHALL register dsel <= the lowest-index set bit of hsel (priority-resolved one-hot), or all-zero if hsel=0.
REQ-016 When dsel is non-zero, SHALL drive hrdata/hready/hresp combinationally as the AND-OR of the selected slave's hrdata_s/hreadyout_s/hresp_s, with zero added latency.
REQ-017 When dsel=0, SHALL drive hrdata=0 and take hready/hresp from the default-slave FSM.
REQ-018 The default-slave FSM SHALL have three states: IDLE (hready=1, hresp=0), ERR1 (hready=0, hresp=1) and ERR2 (hready=1, hresp=1).
REQ-019 On a sample with hsel=0 and htrans[1]=1 (NONSEQ/SEQ), the FSM SHALL go to ERR1; on a sample with hsel=0 and htrans IDLE/BUSY, it SHALL go to IDLE (zero-wait OKAY).
REQ-020 ERR1 SHALL always advance to ERR2 on the next cycle; no address is sampled in ERR1.
REQ-021 ERR2 SHALL sample the address phase (hready=1) and take the next state per REQ-019, or go to IDLE if hsel is non-zero.
REQ-022 On a sample with hsel non-zero, the FSM SHALL go to IDLE, and the data phase SHALL follow the slave per REQ-016, regardless of htrans.
REQ-023 SHALL set onehot_err to 1 when a sample sees two or more bits of hsel set; it stays 1 until reset.
REQ-024 Back-to-back unmapped NONSEQ transfers SHALL each receive the full two-cycle ERROR response.

Reset
REQ-025 While rst=1, SHALL hold dsel=0, FSM=IDLE and onehot_err=0, so outputs are hrdata=0, hready=1, hresp=0.
REQ-026 A reset asserted mid-wait-state or mid-ERROR SHALL abort the transfer immediately (asynchronously); the first cycle after deassertion samples a new address phase.

Structure
REQ-027 Shared package ahb_pkg SHALL hold the HTRANS encodings, the HRESP_OKAY/HRESP_ERROR constants and the default-slave state enum.
REQ-028 SHALL instantiate one sub-module, ahb_onehot_mux #(NSLV, DW): a combinational one-hot AND-OR mux, used once for each of hrdata, hreadyout and hresp.
REQ-029 The priority resolver, dsel register, FSM and sticky flag SHALL reside in ahb_resp_mux.

Verification
REQ-030 Reset then idle: rst pulse, with hsel=0 and htrans=IDLE -> hrdata=0, hready=1, hresp=0, onehot_err=0.
REQ-031 Wait states: hsel=9'h004 with NONSEQ sampled; slave 2 drives hreadyout=0 for 2 cycles then 1 with data 0xCAFE0002 -> hready=0,0,1 and hrdata=0xCAFE0002 in the final cycle; hsel changes during the wait are ignored.
REQ-032 Unmapped access: hsel=0 with NONSEQ sampled -> next two cycles give (hready=0, hresp=1) then (hready=1, hresp=1); a following hsel=0 with IDLE gives hready=1, hresp=0.
REQ-033 Back-to-back errors: hsel=0 with NONSEQ sampled in ERR2 -> ERR1 and ERR2 repeat, 4 cycles in total, hresp=1 throughout.
REQ-034 Multi-hot select: hsel=9'h0A0 sampled -> slave 5's data is selected and onehot_err=1 remains set across later legal transfers until rst.
REQ-035 Reset mid-ERROR: rst asserted during ERR1 -> hready=1 and hresp=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the response multiplexer slice.
// Holds the HTRANS encodings, the HRESP encodings and the state type
// of the built-in default slave that answers unmapped transfers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default-slave states: IDLE gives a zero-wait OKAY, ERR1/ERR2 form the
  // two-cycle ERROR response.
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

endpackage

// File: rtl/ahb_resp_mux_if.sv
// Bus bundle between the AHB master side and the response multiplexer.
//   hsel/htrans           : address-phase select and transfer type
//   hrdata_s/hreadyout_s/hresp_s : packed per-slave data-phase responses
//   hrdata/hready/hresp   : muxed response to the master (hready is also
//                           the bus HREADY fed back to every slave)
//   onehot_err            : sticky multi-hot select flag
// Modport "slave" is the multiplexer's view, "master" the driver's view.
interface ahb_resp_mux_if #(
  parameter int NSLV = 9,
  parameter int DW   = 32
);
  logic [NSLV-1:0]    hsel;
  logic [1:0]         htrans;
  logic [NSLV*DW-1:0] hrdata_s;
  logic [NSLV-1:0]    hreadyout_s;
  logic [NSLV-1:0]    hresp_s;
  logic [DW-1:0]      hrdata;
  logic               hready;
  logic               hresp;
  logic               onehot_err;

  modport slave (
    input  hsel, htrans, hrdata_s, hreadyout_s, hresp_s,
    output hrdata, hready, hresp, onehot_err
  );

  modport master (
    output hsel, htrans, hrdata_s, hreadyout_s, hresp_s,
    input  hrdata, hready, hresp, onehot_err
  );
endinterface

// File: rtl/ahb_onehot_mux.sv
// Combinational one-hot AND-OR multiplexer.
//   sel  : one-hot select, one bit per channel
//   din  : packed channels, channel k in bits [k*DW +: DW]
//   dout : OR of all channels masked by their select bit (zero if sel=0)
module ahb_onehot_mux #(
  parameter int NSLV = 9,
  parameter int DW   = 32
) (
  input  logic [NSLV-1:0]    sel,
  input  logic [NSLV*DW-1:0] din,
  output logic [DW-1:0]      dout
);

  logic [DW-1:0] term [NSLV];

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_term
      assign term[gi] = din[gi*DW +: DW] & {DW{sel[gi]}};
    end
  endgenerate

  always_comb begin
    dout = '0;
    for (int k = 0; k < NSLV; k++) begin
      dout = dout | term[k];
    end
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB data-phase response multiplexer with built-in default slave.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ahb_resp_mux_if.slave bundle (address-phase inputs, per-slave
//          responses in, muxed hrdata/hready/hresp and onehot_err out)
// The address phase is captured only while hready=1. A captured slave
// select routes that slave's response straight through; an empty select
// hands the data phase to the default slave, which answers IDLE/BUSY with
// OKAY and NONSEQ/SEQ with a two-cycle ERROR.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int NSLV = 9,
  parameter int DW   = 32
) (
  input  logic           clk,
  input  logic           rst,
  ahb_resp_mux_if.slave  bus
);

  localparam logic [NSLV-1:0] ONE = NSLV'(1);

  logic [NSLV-1:0] dsel_reg;
  logic [NSLV-1:0] dsel_next;
  ds_state_e       state_reg;
  ds_state_e       state_next;
  logic            onehot_err_reg;

  logic [NSLV-1:0] hsel_lowest;
  logic            hsel_multi;
  logic            trans_active;
  logic            sample;

  logic [DW-1:0]   mux_rdata;
  logic [0:0]      mux_ready;
  logic [0:0]      mux_resp;
  logic            fsm_ready;
  logic            fsm_resp;

  // x & -x isolates the lowest set bit; x & (x-1) clears it, so anything
  // left over means two or more bits were set.
  assign hsel_lowest  = bus.hsel & (~bus.hsel + ONE);
  assign hsel_multi   = |(bus.hsel & (bus.hsel - ONE));
  assign trans_active = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);

  // The muxed HREADY doubles as the bus HREADY, so it also gates capture.
  assign sample = bus.hready;

  ahb_onehot_mux #(.NSLV(NSLV), .DW(DW)) u_mux_rdata (
    .sel  (dsel_reg),
    .din  (bus.hrdata_s),
    .dout (mux_rdata)
  );

  ahb_onehot_mux #(.NSLV(NSLV), .DW(1)) u_mux_ready (
    .sel  (dsel_reg),
    .din  (bus.hreadyout_s),
    .dout (mux_ready)
  );

  ahb_onehot_mux #(.NSLV(NSLV), .DW(1)) u_mux_resp (
    .sel  (dsel_reg),
    .din  (bus.hresp_s),
    .dout (mux_resp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsel_reg       <= '0;
      state_reg      <= DS_IDLE;
      onehot_err_reg <= 1'b0;
    end else begin
      dsel_reg  <= dsel_next;
      state_reg <= state_next;
      if (sample && hsel_multi) begin
        onehot_err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    dsel_next  = dsel_reg;
    state_next = state_reg;
    fsm_ready  = 1'b1;
    fsm_resp   = HRESP_OKAY;

    case (state_reg)
      DS_ERR1: begin
        fsm_ready = 1'b0;
        fsm_resp  = HRESP_ERROR;
      end
      DS_ERR2: begin
        fsm_resp = HRESP_ERROR;
      end
      default: ;
    endcase

    if (state_reg == DS_ERR1) begin
      // First ERROR cycle never captures an address.
      state_next = DS_ERR2;
    end else if (sample) begin
      dsel_next = hsel_lowest;
      if (bus.hsel == '0 && trans_active) begin
        state_next = DS_ERR1;
      end else begin
        state_next = DS_IDLE;
      end
    end
  end

  // With dsel_reg=0 the data mux already yields zero read data.
  assign bus.hrdata     = mux_rdata;
  assign bus.hready     = (|dsel_reg) ? mux_ready[0] : fsm_ready;
  assign bus.hresp      = (|dsel_reg) ? mux_resp[0]  : fsm_resp;
  assign bus.onehot_err = onehot_err_reg;

endmodule

// File: tb/tb_ahb_resp_mux.sv
module tb_ahb_resp_mux;
  import ahb_pkg::*;

  localparam int NSLV = 9;
  localparam int DW   = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ahb_resp_mux_if #(.NSLV(NSLV), .DW(DW)) bus ();

  ahb_resp_mux #(.NSLV(NSLV), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  hsel;
    logic [1:0]  htrans;
    logic [8:0]  rdy;
    logic [8:0]  resp;
    logic        exp_ready;
    logic        exp_resp;
    logic [31:0] exp_data;
    logic        exp_oe;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic r, input logic e,
                               input logic [31:0] d, input logic o);
    check({tag, ".hready"}, {31'b0, bus.hready}, {31'b0, r});
    check({tag, ".hresp"}, {31'b0, bus.hresp}, {31'b0, e});
    check({tag, ".hrdata"}, bus.hrdata, d);
    check({tag, ".onehot_err"}, {31'b0, bus.onehot_err}, {31'b0, o});
  endtask

  task automatic drive(input logic [8:0] hsel, input logic [1:0] htrans,
                       input logic [8:0] rdy, input logic [8:0] resp);
    bus.hsel        = hsel;
    bus.htrans      = htrans;
    bus.hreadyout_s = rdy;
    bus.hresp_s     = resp;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    for (int k = 0; k < NSLV; k++) begin
      bus.hrdata_s[k*DW +: DW] = 32'hCAFE0000 | 32'(k);
    end

    // Each row: inputs applied in one cycle and the outputs expected in that
    // same cycle (set by what earlier rows caused to be captured).
    //              hsel    htrans         rdy      resp    rdy rsp data          oe
    vecs[0]  = '{9'h000, HTRANS_IDLE,   9'h1FF, 9'h000, 1, 0, 32'h0,          0};
    vecs[1]  = '{9'h004, HTRANS_NONSEQ, 9'h1FF, 9'h000, 1, 0, 32'h0,          0};
    vecs[2]  = '{9'h010, HTRANS_NONSEQ, 9'h1FB, 9'h000, 0, 0, 32'hCAFE0002,   0};
    vecs[3]  = '{9'h001, HTRANS_NONSEQ, 9'h1FB, 9'h000, 0, 0, 32'hCAFE0002,   0};
    vecs[4]  = '{9'h000, HTRANS_NONSEQ, 9'h1FF, 9'h000, 1, 0, 32'hCAFE0002,   0};
    vecs[5]  = '{9'h000, HTRANS_IDLE,   9'h1DF, 9'h020, 0, 1, 32'h0,          0};
    vecs[6]  = '{9'h000, HTRANS_IDLE,   9'h1FF, 9'h000, 1, 1, 32'h0,          0};
    vecs[7]  = '{9'h000, HTRANS_NONSEQ, 9'h1FF, 9'h000, 1, 0, 32'h0,          0};
    vecs[8]  = '{9'h000, HTRANS_SEQ,    9'h1FF, 9'h000, 0, 1, 32'h0,          0};
    vecs[9]  = '{9'h000, HTRANS_NONSEQ, 9'h1FF, 9'h000, 1, 1, 32'h0,          0};
    vecs[10] = '{9'h000, HTRANS_IDLE,   9'h1FF, 9'h000, 0, 1, 32'h0,          0};
    vecs[11] = '{9'h0A0, HTRANS_NONSEQ, 9'h1FF, 9'h000, 1, 1, 32'h0,          0};
    vecs[12] = '{9'h002, HTRANS_SEQ,    9'h1DF, 9'h020, 0, 1, 32'hCAFE0005,   1};
    vecs[13] = '{9'h002, HTRANS_SEQ,    9'h1FF, 9'h020, 1, 1, 32'hCAFE0005,   1};
    vecs[14] = '{9'h000, HTRANS_BUSY,   9'h1DF, 9'h020, 1, 0, 32'hCAFE0001,   1};
    vecs[15] = '{9'h000, HTRANS_IDLE,   9'h1DF, 9'h020, 1, 0, 32'h0,          1};

    // Reset held across a few edges with an idle bus.
    drive(9'h000, HTRANS_IDLE, 9'h1FF, 9'h000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].hsel, vecs[i].htrans, vecs[i].rdy, vecs[i].resp);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_resp,
                    vecs[i].exp_data, vecs[i].exp_oe);
      $display("vec%0d hsel=%h htrans=%b -> hready=%b hresp=%b hrdata=%h oe=%b",
               i, vecs[i].hsel, vecs[i].htrans, bus.hready, bus.hresp,
               bus.hrdata, bus.onehot_err);
    end

    // Reset asserted in the middle of ERR1 clears the response at once.
    @(negedge clk);
    drive(9'h000, HTRANS_NONSEQ, 9'h1FF, 9'h000);
    @(negedge clk);
    drive(9'h000, HTRANS_IDLE, 9'h1FF, 9'h000);
    #1;
    check_outputs("err1_before_rst", 1'b0, 1'b1, 32'h0, 1'b1);
    rst = 1'b1;
    #1;
    check_outputs("err1_async_rst", 1'b1, 1'b0, 32'h0, 1'b0);
    $display("async reset in ERR1 -> hready=%b hresp=%b oe=%b",
             bus.hready, bus.hresp, bus.onehot_err);
    @(negedge clk);
    rst = 1'b0;

    // First cycle after reset captures a fresh address phase.
    drive(9'h008, HTRANS_NONSEQ, 9'h1FF, 9'h000);
    @(negedge clk);
    drive(9'h000, HTRANS_IDLE, 9'h1FF, 9'h008);
    #1;
    check_outputs("post_rst_slave3", 1'b1, 1'b1, 32'hCAFE0003, 1'b0);
    $display("post reset slave3 -> hready=%b hresp=%b hrdata=%h",
             bus.hready, bus.hresp, bus.hrdata);
    @(negedge clk);
    #1;
    check_outputs("post_rst_idle", 1'b1, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
